// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared constants and FSM state type for the 16-bit register
//               SPI link, used by the read-response transmitter and the
//               write-side receiver.
// Contents    : FRAME_BITS, HDR_BITS, ADDR_W, RW_READ/RW_WRITE,
//               spi_state_e (frame FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int HDR_BITS   = 8;
    localparam int ADDR_W     = 7;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HEADER     = 3'd1,
        ST_READ_DATA  = 3'd2,
        ST_WRITE_DATA = 3'd3,
        ST_DONE       = 3'd4
    } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_shift_tx.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_tx
// Description : Parallel-load, MSB-first output shift register that drives
//               cipo. Zeros are shifted in behind the data.
// Ports       : sclk  - SPI clock (rising edge)
//               rst_n - asynchronous active-low reset
//               clr   - asynchronous active-high frame clear (cs_n high)
//               load  - load din on the next rising edge (priority)
//               shift - shift left by one on the next rising edge
//               din   - parallel load value
//               cipo  - current MSB
// Revision    : 1.0 - initial release
// ============================================================================
module spi_shift_tx #(
    parameter int WIDTH = 8
) (
    input  logic             sclk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             cipo
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge sclk or negedge rst_n or posedge clr) begin
        if (!rst_n || clr) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= din;
        end else if (shift) begin
            r_data <= {r_data[WIDTH-2:0], 1'b0};
        end
    end

    assign cipo = r_data[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/spi_readback_tx.sv
`default_nettype none
// ============================================================================
// Module      : spi_readback_tx
// Description : Read-response transmitter for the 16-bit register SPI link.
//               Decodes the 8-bit header of each frame and, for reads,
//               shifts the addressed register out on cipo during byte two.
// Ports       : sclk     - SPI clock, sole clock of the block
//               rst_n    - asynchronous active-low reset
//               cs_n     - active-low chip select (high clears frame state)
//               copi     - controller-out data, MSB first
//               reg_bus  - flattened register values, reg n at [n*W +: W]
//               cipo     - controller-in data
//               cipo_oe  - pad drive enable for cipo
//               addr_err - last read frame hit an unimplemented register
//               rd_count - completed valid read frames (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_readback_tx
    import spi_pkg::*;
#(
    parameter int NUM_REGS = 5,
    parameter int DATA_W   = 8
) (
    input  logic                       sclk,
    input  logic                       rst_n,
    input  logic                       cs_n,
    input  logic                       copi,
    input  logic [NUM_REGS*DATA_W-1:0] reg_bus,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic                       addr_err,
    output logic [7:0]                 rd_count
);

    localparam logic [3:0] c_HDR_LAST   = 4'(HDR_BITS - 1);
    localparam logic [3:0] c_FRAME_LAST = 4'(FRAME_BITS - 1);

    spi_state_e          r_state;
    spi_state_e          w_state;
    spi_state_e          w_state_nxt;
    logic [3:0]          r_bit_cnt;
    logic [ADDR_W-1:0]   r_hdr;

    logic                w_rw;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_addr_ok;
    logic [DATA_W-1:0]   w_rd_data;

    logic                w_cnt_en;
    logic                w_hdr_en;
    logic                w_dec_rd;
    logic                w_rd_done;
    logic                w_load;
    logic                w_shift;
    logic [DATA_W-1:0]   w_load_data;

    // Header as seen on the decode edge: 7 shifted bits plus the live copi.
    assign w_rw   = r_hdr[ADDR_W-1];
    assign w_addr = {r_hdr[ADDR_W-2:0], copi};

    always_comb begin
        w_addr_ok = 1'b0;
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_addr == ADDR_W'(i)) begin
                w_addr_ok = 1'b1;
                w_rd_data = reg_bus[i*DATA_W +: DATA_W];
            end
        end
    end

    // The frame register parks at HEADER while cleared, so the frame is live
    // the instant cs_n falls; IDLE is presented whenever the clear is active.
    assign w_state = (!rst_n || cs_n) ? ST_IDLE : r_state;

    always_ff @(posedge sclk or negedge rst_n or posedge cs_n) begin
        if (!rst_n || cs_n) begin
            r_state   <= ST_HEADER;
            r_bit_cnt <= '0;
            r_hdr     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cnt_en) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            if (w_hdr_en) begin
                r_hdr <= {r_hdr[ADDR_W-2:0], copi};
            end
        end
    end

    always_comb begin
        w_state_nxt = w_state;
        w_cnt_en    = 1'b0;
        w_hdr_en    = 1'b0;
        w_dec_rd    = 1'b0;
        w_rd_done   = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_load_data = '0;
        cipo_oe     = 1'b0;
        case (w_state)
            ST_HEADER: begin
                w_cnt_en = 1'b1;
                if (r_bit_cnt == c_HDR_LAST) begin
                    if (w_rw == RW_READ) begin
                        w_state_nxt = ST_READ_DATA;
                        w_dec_rd    = 1'b1;
                        w_load      = 1'b1;
                        w_load_data = w_addr_ok ? w_rd_data : '0;
                    end else begin
                        w_state_nxt = ST_WRITE_DATA;
                    end
                end else begin
                    w_hdr_en = 1'b1;
                end
            end
            ST_READ_DATA: begin
                cipo_oe  = 1'b1;
                w_cnt_en = 1'b1;
                if (r_bit_cnt == c_FRAME_LAST) begin
                    // Reload zero so cipo is already low once oe drops.
                    w_state_nxt = ST_DONE;
                    w_load      = 1'b1;
                    // addr_err was written by this frame's own decode.
                    w_rd_done   = !addr_err;
                end else begin
                    w_shift = 1'b1;
                end
            end
            ST_WRITE_DATA: begin
                w_cnt_en = 1'b1;
                if (r_bit_cnt == c_FRAME_LAST) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = w_state;
            end
        endcase
    end

    // Sticky status survives cs_n; only rst_n clears it.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
            rd_count <= '0;
        end else begin
            if (w_dec_rd) begin
                addr_err <= !w_addr_ok;
            end
            if (w_rd_done) begin
                rd_count <= rd_count + 8'd1;
            end
        end
    end

    spi_shift_tx #(
        .WIDTH (DATA_W)
    ) u_shift_tx (
        .sclk  (sclk),
        .rst_n (rst_n),
        .clr   (cs_n),
        .load  (w_load),
        .shift (w_shift),
        .din   (w_load_data),
        .cipo  (cipo)
    );

endmodule
`default_nettype wire

// File: tb/tb_spi_readback_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_readback_tx
// Description : Self-checking bench for spi_readback_tx. Drives SPI frames
//               bit by bit and compares against a frame-level reference
//               model of the expected response byte and status counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_readback_tx;

    localparam int NUM_REGS = 5;

    logic                   sclk;
    logic                   rst_n;
    logic                   cs_n;
    logic                   copi;
    logic [NUM_REGS*8-1:0]  reg_bus;
    logic                   cipo;
    logic                   cipo_oe;
    logic                   addr_err;
    logic [7:0]             rd_count;

    int unsigned n_assert;
    int unsigned n_fail;

    logic [7:0] m_regs [NUM_REGS];
    logic [7:0] m_cnt;
    logic       m_err;

    spi_readback_tx #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (8)
    ) dut (
        .sclk     (sclk),
        .rst_n    (rst_n),
        .cs_n     (cs_n),
        .copi     (copi),
        .reg_bus  (reg_bus),
        .cipo     (cipo),
        .cipo_oe  (cipo_oe),
        .addr_err (addr_err),
        .rd_count (rd_count)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_regs();
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_bus[i*8 +: 8] = m_regs[i];
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, ".addr_err"}, 8'(addr_err), 8'(m_err));
        check({tag, ".rd_count"}, rd_count, m_cnt);
    endtask

    // One frame: nedges rising edges, optional rst_n pulse after edge rst_at.
    task automatic frame(input logic [7:0] hdr, input logic [7:0] wd,
                         input int nedges, input int rst_at, input bit chk);
        logic [15:0] f;
        logic [7:0]  ed;
        bit          rd;
        bit          ok;
        bit          exp_oe;
        f  = {hdr, wd};
        rd = (hdr[7] == 1'b0);
        ok = rd && (int'(hdr[6:0]) < NUM_REGS);
        ed = 8'h00;
        if (ok) ed = m_regs[hdr[6:0]];
        cs_n = 1'b0;
        #5;
        for (int e = 1; e <= nedges; e++) begin
            copi = (e <= 16) ? f[16-e] : 1'($urandom_range(0, 1));
            #5 sclk = 1'b1;
            #1;
            if (e == 8 && rd) m_err = !ok;
            if (e == 16 && ok) m_cnt = m_cnt + 8'd1;
            if (chk) begin
                exp_oe = rd && (e >= 8) && (e <= 15);
                check("cipo_oe", 8'(cipo_oe), 8'(exp_oe));
                check("cipo", 8'(cipo), exp_oe ? 8'(ed[15-e]) : 8'h00);
                check_status("edge");
            end
            if (e == rst_at) begin
                rst_n = 1'b0;
                #1;
                m_cnt = 8'h00;
                m_err = 1'b0;
                check("rst.cipo", 8'(cipo), 8'h00);
                check("rst.cipo_oe", 8'(cipo_oe), 8'h00);
                check_status("rst");
                #3 sclk = 1'b0;
                #5 rst_n = 1'b1;
                break;
            end
            #4 sclk = 1'b0;
            #5;
        end
        #5 cs_n = 1'b1;
        #1;
        check("end.cipo_oe", 8'(cipo_oe), 8'h00);
        check("end.cipo", 8'(cipo), 8'h00);
        check_status("end");
        #10;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        sclk     = 1'b0;
        cs_n     = 1'b1;
        copi     = 1'b0;
        rst_n    = 1'b0;
        m_cnt    = 8'h00;
        m_err    = 1'b0;
        m_regs[0] = 8'h11;
        m_regs[1] = 8'h22;
        m_regs[2] = 8'h33;
        m_regs[3] = 8'h44;
        m_regs[4] = 8'h55;
        set_regs();
        #10;
        check("reset.cipo", 8'(cipo), 8'h00);
        check("reset.cipo_oe", 8'(cipo_oe), 8'h00);
        check("reset.addr_err", 8'(addr_err), 8'h00);
        check("reset.rd_count", rd_count, 8'h00);
        rst_n = 1'b1;
        #10;

        // Directed: valid read, invalid read, recovery, write.
        frame(8'h02, 8'h00, 16, 0, 1'b1);
        check("rd2.count", rd_count, 8'd1);
        frame(8'h7F, 8'h00, 16, 0, 1'b1);
        check("rd7f.err", 8'(addr_err), 8'h01);
        frame(8'h00, 8'h00, 16, 0, 1'b1);
        check("rd0.err", 8'(addr_err), 8'h00);
        frame(8'h81, 8'h55, 16, 0, 1'b1);
        check("wr.count", rd_count, 8'd2);

        // Abort after edge 11, then full read of the same address.
        frame(8'h04, 8'h00, 11, 0, 1'b1);
        frame(8'h04, 8'h00, 16, 0, 1'b1);
        check("abort.count", rd_count, 8'd3);

        // Extra edges past the end of frame.
        frame(8'h03, 8'h00, 20, 0, 1'b1);
        check("extra.count", rd_count, 8'd4);

        // Short frame: no decode.
        frame(8'h7F, 8'h00, 5, 0, 1'b1);

        // Reset mid-read, then a fresh frame.
        frame(8'h01, 8'h00, 10, 10, 1'b1);
        frame(8'h01, 8'h00, 16, 0, 1'b1);
        check("postrst.count", rd_count, 8'd1);

        // Wrap: clear, then 256 valid reads.
        rst_n = 1'b0;
        #2;
        m_cnt = 8'h00;
        m_err = 1'b0;
        check("wrap.rst", rd_count, 8'h00);
        rst_n = 1'b1;
        #10;
        for (int i = 0; i < 256; i++) begin
            frame({1'b0, 7'($urandom_range(0, NUM_REGS-1))}, 8'h00, 16, 0, 1'b0);
        end
        check("wrap.count", rd_count, 8'h00);

        // Randomized frames against the model.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] hdr;
            int         ne;
            int         pick;
            for (int r = 0; r < NUM_REGS; r++) begin
                m_regs[r] = 8'($urandom);
            end
            set_regs();
            hdr[7]   = ($urandom_range(0, 3) == 0);
            hdr[6:0] = ($urandom_range(0, 4) == 0) ? 7'($urandom)
                                                   : 7'($urandom_range(0, 7));
            pick = int'($urandom_range(0, 9));
            ne   = (pick == 0) ? 5 : (pick == 1) ? 12 : (pick == 2) ? 20 : 16;
            frame(hdr, 8'($urandom), ne, 0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
